// File: rtl/vga_timing_pkg.sv
// Shared raster-timing constants and types for the VGA timing generator.
// Defaults describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_timing_pkg;

   localparam int unsigned POS_W     = 10;
   localparam int unsigned MAX_TOTAL = 1 << POS_W;

   typedef logic [POS_W-1:0] pos_t;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
      return active + fp;
   endfunction

   localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   localparam int unsigned DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
   localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
   localparam int unsigned DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
   localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: count enable in, registered position/sync/strobe outputs.
interface vga_timing_gen_if #(
   parameter int unsigned FCNT_W = 8
);
   import vga_timing_pkg::*;

   logic              ena;
   logic              hsync;
   logic              vsync;
   logic              activevideo;
   pos_t              x_px;
   pos_t              y_px;
   logic              line_start;
   logic              frame_start;
   logic [FCNT_W-1:0] frame_cnt;

   modport master (
      input  ena,
      output hsync,
      output vsync,
      output activevideo,
      output x_px,
      output y_px,
      output line_start,
      output frame_start,
      output frame_cnt
   );

   modport slave (
      output ena,
      input  hsync,
      input  vsync,
      input  activevideo,
      input  x_px,
      input  y_px,
      input  line_start,
      input  frame_start,
      input  frame_cnt
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, registered sync level and the
// next-state active flag so the parent can register a combined visibility bit.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE          = DEF_H_ACTIVE,
   parameter int unsigned FP              = DEF_H_FP,
   parameter int unsigned SYNC            = DEF_H_SYNC,
   parameter int unsigned BP              = DEF_H_BP,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic step,
   output pos_t pos,
   output logic wrap,
   output logic sync,
   output logic active_nxt
);

   localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam int unsigned SYNC_START = sync_start(ACTIVE, FP);
   localparam int unsigned SYNC_END   = SYNC_START + SYNC - 1;
   localparam pos_t        LAST       = pos_t'(TOTAL - 1);

   if (TOTAL > MAX_TOTAL) begin : g_total_chk
      $error("vga_axis_counter: total %0d exceeds %0d", TOTAL, MAX_TOTAL);
   end
   if ((SYNC == 0) || (SYNC_START + SYNC > TOTAL)) begin : g_sync_chk
      $error("vga_axis_counter: sync window [%0d,%0d] outside total %0d",
             SYNC_START, SYNC_END, TOTAL);
   end

   pos_t pos_q, pos_d;
   logic sync_q, sync_d;
   logic in_sync;

   always_comb begin
      wrap  = ena && step && (pos_q == LAST);
      pos_d = pos_q;
      if (ena && step) begin
         pos_d = wrap ? '0 : pos_q + 1'b1;
      end
      // Flags are decoded from pos_d so they line up with the registered position.
      in_sync    = (32'(pos_d) >= SYNC_START) && (32'(pos_d) <= SYNC_END);
      sync_d     = in_sync ^ SYNC_ACTIVE_LOW;
      active_nxt = 32'(pos_d) < ACTIVE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q  <= '0;
         sync_q <= SYNC_ACTIVE_LOW;
      end else begin
         pos_q  <= pos_d;
         sync_q <= sync_d;
      end
   end

   assign pos  = pos_q;
   assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y position, syncs, visibility, line/frame strobes
// and a free-running frame counter, all registered and mutually aligned.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
   parameter int unsigned H_FP            = DEF_H_FP,
   parameter int unsigned H_SYNC          = DEF_H_SYNC,
   parameter int unsigned H_BP            = DEF_H_BP,
   parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
   parameter int unsigned V_FP            = DEF_V_FP,
   parameter int unsigned V_SYNC          = DEF_V_SYNC,
   parameter int unsigned V_BP            = DEF_V_BP,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter int unsigned FCNT_W          = 8
) (
   input logic              clk,
   input logic              rst_n,
   vga_timing_gen_if.master bus
);

   pos_t              x_q, y_q;
   logic              hsync_q, vsync_q;
   logic              h_wrap, v_wrap;
   logic              h_active_nxt, v_active_nxt;
   logic              activevideo_q;
   logic              line_start_q, frame_start_q;
   logic [FCNT_W-1:0] frame_cnt_q;

   vga_axis_counter #(
      .ACTIVE          (H_ACTIVE),
      .FP              (H_FP),
      .SYNC            (H_SYNC),
      .BP              (H_BP),
      .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_h_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (bus.ena),
      .step       (1'b1),
      .pos        (x_q),
      .wrap       (h_wrap),
      .sync       (hsync_q),
      .active_nxt (h_active_nxt)
   );

   vga_axis_counter #(
      .ACTIVE          (V_ACTIVE),
      .FP              (V_FP),
      .SYNC            (V_SYNC),
      .BP              (V_BP),
      .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_v_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (bus.ena),
      .step       (h_wrap),
      .pos        (y_q),
      .wrap       (v_wrap),
      .sync       (vsync_q),
      .active_nxt (v_active_nxt)
   );

   // Both wrap flags already carry ena, so strobes clear while counting is frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         activevideo_q <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         activevideo_q <= h_active_nxt && v_active_nxt;
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
         if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.activevideo = activevideo_q;
   assign bus.x_px        = x_q;
   assign bus.y_px        = y_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance plus a tiny-raster instance, both checked each
// cycle against an arithmetic model driven by the count of enabled clocks.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int unsigned SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 4;
   localparam int unsigned SV_A = 8, SV_F = 2, SV_S = 2, SV_B = 3;
   localparam int unsigned SM_FRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

   logic clk = 1'b0;
   logic rst_n;
   logic ena;

   int checks = 0;
   int errors = 0;

   // Model state: enabled clocks since reset, and whether the last edge advanced.
   int unsigned n;
   bit          stepped;

   vga_timing_gen_if #(.FCNT_W(8)) if_def ();
   vga_timing_gen_if #(.FCNT_W(3)) if_sm ();

   assign if_def.ena = ena;
   assign if_sm.ena  = ena;

   vga_timing_gen #(
      .FCNT_W (8)
   ) u_def (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_def)
   );

   vga_timing_gen #(
      .H_ACTIVE        (SH_A),
      .H_FP            (SH_F),
      .H_SYNC          (SH_S),
      .H_BP            (SH_B),
      .V_ACTIVE        (SV_A),
      .V_FP            (SV_F),
      .V_SYNC          (SV_S),
      .V_BP            (SV_B),
      .SYNC_ACTIVE_LOW (1'b0),
      .FCNT_W          (3)
   ) u_sm (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_sm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", tag, got, exp, n, $time);
      end
   endtask

   task automatic check_axis(input string p,
                             input int unsigned ha, input int unsigned hf,
                             input int unsigned hs, input int unsigned hb,
                             input int unsigned va, input int unsigned vf,
                             input int unsigned vs, input int unsigned vb,
                             input bit low, input int unsigned fw,
                             input logic hs_o, input logic vs_o, input logic av_o,
                             input logic ls_o, input logic fs_o,
                             input logic [9:0] x_o, input logic [9:0] y_o,
                             input logic [7:0] fc_o);
      int unsigned ht, vt, x, line, y, fr;
      bit in_h, in_v;
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      x    = n % ht;
      line = n / ht;
      y    = line % vt;
      fr   = (line / vt) % (32'd1 << fw);
      in_h = (x >= ha + hf) && (x < ha + hf + hs);
      in_v = (y >= va + vf) && (y < va + vf + vs);
      check({p, "_x"}, 32'(x_o), x);
      check({p, "_y"}, 32'(y_o), y);
      check({p, "_hsync"}, 32'(hs_o), 32'(in_h ^ low));
      check({p, "_vsync"}, 32'(vs_o), 32'(in_v ^ low));
      check({p, "_active"}, 32'(av_o), 32'((x < ha) && (y < va)));
      check({p, "_line_start"}, 32'(ls_o), 32'(stepped && (x == 0)));
      check({p, "_frame_start"}, 32'(fs_o), 32'(stepped && (x == 0) && (y == 0)));
      check({p, "_frame_cnt"}, 32'(fc_o), fr);
   endtask

   task automatic check_all();
      check_axis("def", DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                 DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, 1'b1, 8,
                 if_def.hsync, if_def.vsync, if_def.activevideo,
                 if_def.line_start, if_def.frame_start,
                 if_def.x_px, if_def.y_px, if_def.frame_cnt);
      check_axis("sm", SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b0, 3,
                 if_sm.hsync, if_sm.vsync, if_sm.activevideo,
                 if_sm.line_start, if_sm.frame_start,
                 if_sm.x_px, if_sm.y_px, {5'b0, if_sm.frame_cnt});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (ena) begin
            n++;
            stepped = 1'b1;
         end else begin
            stepped = 1'b0;
         end
      end
      @(negedge clk);
      check_all();
   endtask

   // Called just after a falling edge, so the whole pulse sits between clock edges.
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      n       = 0;
      stepped = 1'b0;
      check_all();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      rst_n   = 1'b0;
      ena     = 1'b0;
      n       = 0;
      stepped = 1'b0;
      repeat (3) @(negedge clk);
      check_all();
      check("rst_def_active", 32'(if_def.activevideo), 32'd1);
      check("rst_def_hsync", 32'(if_def.hsync), 32'd1);
      check("rst_sm_hsync", 32'(if_sm.hsync), 32'd0);

      rst_n = 1'b1;
      ena   = 1'b1;
      repeat (800) tick();
      check("line_wrap_x", 32'(if_def.x_px), 32'd0);
      check("line_wrap_y", 32'(if_def.y_px), 32'd1);
      check("line_wrap_ls", 32'(if_def.line_start), 32'd1);
      check("line_wrap_fs", 32'(if_def.frame_start), 32'd0);
      repeat (900) tick();

      for (int i = 0; i < 6000; i++) begin
         ena = ($urandom_range(3) != 0);
         if ($urandom_range(999) == 0) async_reset();
         tick();
      end

      // Freeze the small raster on its last pixel, then resume into a new frame.
      ena   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 2 * SM_FRAME && !found; i++) begin
         if (n % SM_FRAME == SM_FRAME - 1) found = 1'b1;
         else tick();
      end
      check("sm_hold_reached", 32'(found), 32'd1);
      ena = 1'b0;
      repeat (10) tick();
      check("sm_hold_x", 32'(if_sm.x_px), SH_A + SH_F + SH_S + SH_B - 1);
      check("sm_hold_fs_off", 32'(if_sm.frame_start), 32'd0);
      ena = 1'b1;
      tick();
      check("sm_resume_x", 32'(if_sm.x_px), 32'd0);
      check("sm_resume_y", 32'(if_sm.y_px), 32'd0);
      check("sm_resume_fs", 32'(if_sm.frame_start), 32'd1);

      // Asynchronous reset inside the default hsync pulse.
      found = 1'b0;
      for (int i = 0; i < 2 * DEF_H_TOTAL && !found; i++) begin
         if (n % DEF_H_TOTAL == 700) found = 1'b1;
         else tick();
      end
      check("arst_reached", 32'(found), 32'd1);
      check("arst_pre_hsync", 32'(if_def.hsync), 32'd0);
      rst_n = 1'b0;
      #1;
      check("arst_hsync", 32'(if_def.hsync), 32'd1);
      check("arst_x", 32'(if_def.x_px), 32'd0);
      check("arst_active", 32'(if_def.activevideo), 32'd1);
      n       = 0;
      stepped = 1'b0;
      check_all();
      #1;
      rst_n = 1'b1;
      tick();
      check("arst_resume_x", 32'(if_def.x_px), 32'd1);
      check("arst_resume_ls", 32'(if_def.line_start), 32'd0);
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
